// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversample tick positions,
// parity encodings and the RX threshold decoder.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [3:0] OVERSAMPLE_MID = 4'd7;
  localparam logic [3:0] OVERSAMPLE_END = 4'd15;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  function automatic logic [4:0] thr_decode(input logic [1:0] sel);
    logic [4:0] thr;
    thr = 5'd1;
    case (sel)
      2'b00:   thr = 5'd1;
      2'b01:   thr = 5'd4;
      2'b10:   thr = 5'd8;
      default: thr = 5'd14;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO for received words {frame_err, parity_err, data}.
// A push into a full FIFO is dropped unless a pop frees the slot in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_overrun = i_push & o_full & ~w_do_pop;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: rxd synchronizer, 16x oversampled deframing FSM with
// parity/framing checks, RX FIFO with registered head, status and threshold flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bclk,
  input  logic       rxd,
  input  logic       rx_en,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       read_en,
  input  logic       err_clr,
  input  logic [1:0] rx_thr_val,
  output logic [7:0] data_out,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       rx_thr,
  output logic       rx_bclk_en,
  output rx_state_t  dbg_state
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxs;
  rx_state_t              r_state;
  logic                   r_armed;
  logic [TW-1:0]          r_tcnt;
  logic [2:0]             r_bcnt;
  logic [7:0]             r_shreg;
  logic                   r_pbit;
  logic                   r_par_en;
  logic                   r_par_type;
  logic                   r_push;
  logic [9:0]             r_wdata;

  logic [9:0]             w_head;
  logic [CW-1:0]          w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_ovf;

  logic [7:0]             r_data_out;
  logic                   r_parity_err;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   r_rx_empty;
  logic                   r_rx_full;
  logic                   r_rx_thr;

  // Preset to 1 so reset looks like an idle line, not a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '1;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
  end
  assign w_rxs = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_armed    <= 1'b0;
      r_tcnt     <= '0;
      r_bcnt     <= '0;
      r_shreg    <= '0;
      r_pbit     <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_push     <= 1'b0;
      r_wdata    <= '0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        IDLE: begin
          // armed requires a high line first, so a held-low break cannot retrigger.
          if (rx_en && r_armed && !w_rxs) begin
            r_state    <= START;
            r_tcnt     <= '0;
            r_armed    <= 1'b0;
            r_par_en   <= parity_en;
            r_par_type <= parity_type;
          end else if (w_rxs) begin
            r_armed <= 1'b1;
          end
        end
        START: if (bclk) begin
          if (r_tcnt == TW'(OVERSAMPLE_MID)) begin
            if (w_rxs) begin
              r_state <= IDLE;
            end else begin
              r_tcnt  <= '0;
              r_bcnt  <= '0;
              r_state <= DATA;
            end
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        DATA: if (bclk) begin
          r_tcnt <= r_tcnt + 1'b1;
          if (r_tcnt == TW'(OVERSAMPLE_END)) begin
            r_shreg <= {w_rxs, r_shreg[7:1]};
            r_bcnt  <= r_bcnt + 1'b1;
            if (r_bcnt == 3'd7) r_state <= r_par_en ? PARITY : STOP;
          end
        end
        PARITY: if (bclk) begin
          r_tcnt <= r_tcnt + 1'b1;
          if (r_tcnt == TW'(OVERSAMPLE_END)) begin
            r_pbit  <= w_rxs;
            r_state <= STOP;
          end
        end
        STOP: if (bclk) begin
          r_tcnt <= r_tcnt + 1'b1;
          if (r_tcnt == TW'(OVERSAMPLE_END)) begin
            r_push  <= 1'b1;
            r_wdata <= {~w_rxs, r_par_en & (^r_shreg ^ r_pbit ^ r_par_type), r_shreg};
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (r_push),
    .i_wdata   (r_wdata),
    .i_pop     (read_en),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_overrun (w_ovf)
  );

  // Head word and flags read as zero whenever the FIFO holds nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out   <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_rx_empty   <= 1'b1;
      r_rx_full    <= 1'b0;
      r_rx_thr     <= 1'b0;
    end else begin
      r_data_out   <= w_empty ? 8'h00 : w_head[7:0];
      r_parity_err <= ~w_empty & w_head[8];
      r_frame_err  <= ~w_empty & w_head[9];
      r_rx_empty   <= w_empty;
      r_rx_full    <= w_full;
      r_rx_thr     <= (32'(w_count) >= 32'(thr_decode(rx_thr_val)));
      if (w_ovf)        r_overrun <= 1'b1;
      else if (err_clr) r_overrun <= 1'b0;
    end
  end

  assign data_out    = r_data_out;
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun;
  assign rx_empty    = r_rx_empty;
  assign rx_full     = r_rx_full;
  assign rx_thr      = r_rx_thr;
  assign rx_bclk_en  = rx_en | (r_state != IDLE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of single frames plus hand-written
// sequences for break, false start, rx_en drop, FIFO overrun, threshold and reset.
module tb_uart_receiver;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bclk = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_en = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic       read_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [1:0] rx_thr_val = 2'b00;
  logic [7:0] data_out;
  logic       parity_err, frame_err, overrun_err;
  logic       rx_empty, rx_full, rx_thr, rx_bclk_en;
  rx_state_t  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  int div = 0;

  uart_receiver dut (
    .clk         (clk),
    .reset       (reset),
    .bclk        (bclk),
    .rxd         (rxd),
    .rx_en       (rx_en),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .read_en     (read_en),
    .err_clr     (err_clr),
    .rx_thr_val  (rx_thr_val),
    .data_out    (data_out),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .rx_empty    (rx_empty),
    .rx_full     (rx_full),
    .rx_thr      (rx_thr),
    .rx_bclk_en  (rx_bclk_en),
    .dbg_state   (dbg_state)
  );

  // clock / tick generation: bclk is one clk wide every 4 clks
  always #5 clk = ~clk;
  always @(negedge clk) begin
    bclk = (div == 3);
    div  = (div + 1) % 4;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: one bit = 16 ticks = 64 clks
  task automatic hold_ticks(input int n);
    repeat (n * 4) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    hold_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(stop);
    rxd = 1'b1;
    hold_ticks(2);
  endtask

  task automatic pop();
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       ptype;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[7];
  logic [7:0] exp_q[$];

  initial begin
    logic hit;
    int   k;
    logic [7:0] exp_b;

    vecs[0] = '{8'hA5, 1'b1, PARITY_EVEN, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, PARITY_EVEN, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, PARITY_EVEN, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h01, 1'b1, PARITY_ODD,  1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b1, PARITY_ODD,  1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, PARITY_EVEN, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 1'b0, PARITY_ODD,  1'b1, 1'b1, 8'h80, 1'b0, 1'b0};

    // reset state
    repeat (5) @(negedge clk);
    check("rst data_out", 32'(data_out), 32'h0);
    check("rst parity_err", 32'(parity_err), 32'h0);
    check("rst frame_err", 32'(frame_err), 32'h0);
    check("rst overrun_err", 32'(overrun_err), 32'h0);
    check("rst rx_empty", 32'(rx_empty), 32'h1);
    check("rst rx_full", 32'(rx_full), 32'h0);
    check("rst rx_thr", 32'(rx_thr), 32'h0);
    check("rst rx_bclk_en", 32'(rx_bclk_en), 32'h0);
    check("rst state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    hold_ticks(2);
    rx_en = 1'b1;
    @(negedge clk);
    check("bclk_en on rx_en", 32'(rx_bclk_en), 32'h1);
    hold_ticks(2);

    // table-driven single frames
    for (int i = 0; i < 7; i++) begin
      parity_en   = vecs[i].pen;
      parity_type = vecs[i].ptype;
      send_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].stop);
      check($sformatf("v%0d data", i), 32'(data_out), 32'(vecs[i].exp_data));
      check($sformatf("v%0d pe", i), 32'(parity_err), 32'(vecs[i].exp_pe));
      check($sformatf("v%0d fe", i), 32'(frame_err), 32'(vecs[i].exp_fe));
      check($sformatf("v%0d not empty", i), 32'(rx_empty), 32'h0);
      pop();
      check($sformatf("v%0d empty after read", i), 32'(rx_empty), 32'h1);
    end

    // break: bad stop bit then line held low must not retrigger
    parity_en = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_b = 8'h3C;
      send_bit(exp_b[i]);
    end
    rxd = 1'b0;
    hold_ticks(56);
    check("break data", 32'(data_out), 32'h3C);
    check("break fe", 32'(frame_err), 32'h1);
    pop();
    hold_ticks(40);
    check("break no retrigger", 32'(rx_empty), 32'h1);
    check("break state", 32'(dbg_state), 32'(IDLE));
    rxd = 1'b1;
    hold_ticks(2);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check("after break data", 32'(data_out), 32'h5A);
    check("after break fe", 32'(frame_err), 32'h0);
    pop();

    // false start: 4 ticks low
    rxd = 1'b0;
    hold_ticks(4);
    rxd = 1'b1;
    hold_ticks(20);
    check("false start state", 32'(dbg_state), 32'(IDLE));
    check("false start empty", 32'(rx_empty), 32'h1);
    check("false start pe", 32'(parity_err), 32'h0);
    check("false start fe", 32'(frame_err), 32'h0);
    check("false start ovr", 32'(overrun_err), 32'h0);

    // rx_en dropped mid-frame: frame completes, next frame ignored
    fork
      send_frame(8'h96, 1'b0, 1'b0, 1'b1);
      begin
        hold_ticks(40);
        rx_en = 1'b0;
      end
    join
    check("rx_en drop data", 32'(data_out), 32'h96);
    check("rx_en drop stored", 32'(rx_empty), 32'h0);
    pop();
    send_frame(8'h69, 1'b0, 1'b0, 1'b1);
    check("rx_en off ignored", 32'(rx_empty), 32'h1);
    check("rx_en off bclk_en", 32'(rx_bclk_en), 32'h0);
    rx_en = 1'b1;
    hold_ticks(2);

    // fill to full, then overrun
    for (int i = 0; i < 16; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 1'b1);
      exp_q.push_back(8'(i));
    end
    check("full rx_full", 32'(rx_full), 32'h1);
    check("full no overrun", 32'(overrun_err), 32'h0);
    send_frame(8'h10, 1'b0, 1'b0, 1'b1);
    check("overrun set", 32'(overrun_err), 32'h1);
    check("overrun still full", 32'(rx_full), 32'h1);
    check("overrun head", 32'(data_out), 32'h00);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    check("err_clr", 32'(overrun_err), 32'h0);

    // push and pop in the same cycle while full
    hit = 1'b0;
    fork
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      begin
        k = 0;
        while (!hit && k < 1000) begin
          @(negedge clk);
          if (dut.r_push) begin
            read_en = 1'b1;
            @(negedge clk);
            read_en = 1'b0;
            hit = 1'b1;
          end
          k++;
        end
      end
    join
    check("push/pop found", 32'(hit), 32'h1);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h11);
    check("push/pop no overrun", 32'(overrun_err), 32'h0);
    check("push/pop full", 32'(rx_full), 32'h1);
    for (int i = 0; i < 16; i++) begin
      exp_b = exp_q.pop_front();
      check($sformatf("drain %0d", i), 32'(data_out), 32'(exp_b));
      pop();
    end
    check("drain empty", 32'(rx_empty), 32'h1);
    check("drain not full", 32'(rx_full), 32'h0);

    // threshold of 4
    rx_thr_val = 2'b01;
    send_frame(8'h21, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    send_frame(8'h23, 1'b0, 1'b0, 1'b1);
    check("thr after 3", 32'(rx_thr), 32'h0);
    send_frame(8'h24, 1'b0, 1'b0, 1'b1);
    check("thr after 4", 32'(rx_thr), 32'h1);
    pop();
    check("thr after read", 32'(rx_thr), 32'h0);
    check("head after read", 32'(data_out), 32'h22);

    // asynchronous reset in the middle of a frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    #1;
    check("mid rst empty", 32'(rx_empty), 32'h1);
    check("mid rst data", 32'(data_out), 32'h0);
    check("mid rst thr", 32'(rx_thr), 32'h0);
    check("mid rst full", 32'(rx_full), 32'h0);
    check("mid rst pe", 32'(parity_err), 32'h0);
    check("mid rst fe", 32'(frame_err), 32'h0);
    check("mid rst ovr", 32'(overrun_err), 32'h0);
    check("mid rst state", 32'(dbg_state), 32'(IDLE));
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
